bf_run_checker: RTL and testbench

- Parametrised run-and-check controller for the bellmanford accelerator, replacing fixed-delay, time-based result checking.
- Sequences DUT reset and waits for completion with a cycle watchdog.
- Then scans the Output Memory read port against a golden-result memory and reports pass/fail, mismatch count, first failing address and negative-cycle agreement.
- Synthesisable; sits beside the bellmanford instance and its SRAMs, on bench or FPGA.

---
 rtl/bf_pkg.sv | 7 +
 rtl/bf_cmp_pipe.sv | 68 ++++++
 rtl/bf_run_checker.sv | 135 +++++++++++++
 tb/tb_bf_run_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the bellmanford accelerator and its run/check controller.
package bf_pkg;
  localparam int BF_ADDR_W = 13;
  localparam int BF_DATA_W = 16;

  typedef enum logic [2:0] {IDLE, RST, RUN, SCAN, REPORT} bf_state_e;
endpackage

// File: rtl/bf_cmp_pipe.sv
// Read-latency address delay line, output/golden word compare and saturating mismatch tally.
module bf_cmp_pipe #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              vld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              mis,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] first_addr
);
  logic              vld_s;
  logic [ADDR_W-1:0] addr_s;
  logic              seen;

  if (RD_LAT == 0) begin : g_comb
    assign vld_s  = vld;
    assign addr_s = addr;
  end else begin : g_reg
    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][ADDR_W-1:0] addr_pipe;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_pipe  <= '0;
        addr_pipe <= '0;
      end else if (clr) begin
        vld_pipe  <= '0;
        addr_pipe <= '0;
      end else begin
        vld_pipe[1]  <= vld;
        addr_pipe[1] <= addr;
        for (int k = 2; k <= RD_LAT; k++) begin
          vld_pipe[k]  <= vld_pipe[k-1];
          addr_pipe[k] <= addr_pipe[k-1];
        end
      end
    end
    assign vld_s  = vld_pipe[RD_LAT];
    assign addr_s = addr_pipe[RD_LAT];
  end

  assign mis = vld_s && (a != b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      first_addr <= '0;
      seen       <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      first_addr <= '0;
      seen       <= 1'b0;
    end else if (mis) begin
      if (count != '1) count <= count + 1'b1;
      if (!seen) begin
        first_addr <= addr_s;
        seen       <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bf_run_checker.sv
// Run-and-check controller: resets the DUT, watchdogs its run, then scans
// Output Memory against golden data and reports the verdict.
module bf_run_checker
  import bf_pkg::*;
#(
  parameter int ADDR_W    = BF_ADDR_W,
  parameter int DATA_W    = BF_DATA_W,
  parameter int NUM_VERTS = 64,
  parameter int RST_HOLD  = 2,
  parameter int TIMEOUT   = 10000,
  parameter int RD_LAT    = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              expect_neg,
  output logic              dut_reset,
  input  logic              dut_done,
  input  logic              neg_cycle,
  output logic [ADDR_W-1:0] om_addr,
  input  logic [DATA_W-1:0] om_data,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [ADDR_W-1:0] first_mismatch_addr
);
  if (NUM_VERTS < 1 || longint'(NUM_VERTS) > (64'd1 << ADDR_W)) begin : g_bad_verts
    $error("bf_run_checker: NUM_VERTS does not fit in ADDR_W address bits");
  end
  if (RST_HOLD < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bf_run_checker: RST_HOLD and TIMEOUT must be at least 1");
  end

  bf_state_e         state, nxt;
  logic              accept;
  logic [31:0]       hold_q, wd_q, sc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              exp_neg_q, neg_q, pass_q, tmo_q;
  logic              scan_vld, mis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // done beats the watchdog when both land in the same RUN cycle
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    case (state)
      IDLE, REPORT: if (start) begin
        nxt    = RST;
        accept = 1'b1;
      end
      RST:  if (hold_q == 32'd0) nxt = RUN;
      RUN:  begin
        if (dut_done)                nxt = SCAN;
        else if (wd_q == TIMEOUT-1)  nxt = REPORT;
      end
      SCAN: if (exp_neg_q || sc_q == NUM_VERTS+RD_LAT-1) nxt = REPORT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      wd_q      <= '0;
      sc_q      <= '0;
      addr_q    <= '0;
      exp_neg_q <= 1'b0;
      neg_q     <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      if (accept) begin
        exp_neg_q <= expect_neg;
        hold_q    <= RST_HOLD - 1;
        addr_q    <= '0;
        neg_q     <= 1'b0;
        pass_q    <= 1'b0;
        tmo_q     <= 1'b0;
      end
      case (state)
        RST: begin
          hold_q <= hold_q - 32'd1;
          wd_q   <= '0;
        end
        RUN: begin
          wd_q  <= wd_q + 32'd1;
          sc_q  <= '0;
          neg_q <= neg_cycle;
          if (!dut_done && wd_q == TIMEOUT-1) tmo_q <= 1'b1;
        end
        SCAN: begin
          sc_q <= sc_q + 32'd1;
          if (sc_q < NUM_VERTS-1) addr_q <= addr_q + 1'b1;
          // last compare is still in flight this cycle, so fold in mis
          if (nxt == REPORT)
            pass_q <= exp_neg_q ? neg_q : (!neg_q && mismatch_count == '0 && !mis);
        end
        default: ;
      endcase
    end
  end

  assign scan_vld  = (state == SCAN) && !exp_neg_q && (sc_q < NUM_VERTS);
  assign dut_reset = (state == IDLE) || (state == RST);
  assign busy      = (state == RST) || (state == RUN) || (state == SCAN);
  assign done      = (state == REPORT);
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign om_addr   = addr_q;
  assign gold_addr = addr_q;

  bf_cmp_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) u_cmp (
    .clock      (clock),
    .reset      (reset),
    .clr        (accept),
    .vld        (scan_vld),
    .addr       (addr_q),
    .a          (om_data),
    .b          (gold_data),
    .mis        (mis),
    .count      (mismatch_count),
    .first_addr (first_mismatch_addr)
  );
endmodule

// File: tb/tb_bf_run_checker.sv
// Scoreboarded random bench: two checkers (combinational and registered memories)
// run side by side against a plain-arithmetic reference model.
module tb_bf_run_checker;
  localparam int AW = 13, DW = 16, NV = 8, RH = 2, TO = 100;
  localparam int CW0 = 2, CW1 = 16;

  typedef struct {
    int pass; int tmo; int cnt; int first; int maxa; int lat;
  } exp_t;

  logic clock = 1'b0, reset;
  logic start, expect_neg, dut_done, neg_cycle;
  logic           dut_reset0, busy0, done0, pass0, timeout0;
  logic [AW-1:0]  om_addr0, gold_addr0, first0;
  logic [DW-1:0]  om_data0, gold_data0;
  logic [CW0-1:0] count0;
  logic           dut_reset1, busy1, done1, pass1, timeout1;
  logic [AW-1:0]  om_addr1, gold_addr1, first1;
  logic [DW-1:0]  om_data1, gold_data1;
  logic [CW1-1:0] count1;

  logic [DW-1:0] om_mem [NV];
  logic [DW-1:0] gold_mem [NV];

  exp_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0;
  int max0 = 0, max1 = 0;
  bit done0_p = 0, done1_p = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  bf_run_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_VERTS(NV), .RST_HOLD(RH),
                   .TIMEOUT(TO), .RD_LAT(0), .CNT_W(CW0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .expect_neg(expect_neg),
    .dut_reset(dut_reset0), .dut_done(dut_done), .neg_cycle(neg_cycle),
    .om_addr(om_addr0), .om_data(om_data0), .gold_addr(gold_addr0), .gold_data(gold_data0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(timeout0),
    .mismatch_count(count0), .first_mismatch_addr(first0));

  bf_run_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_VERTS(NV), .RST_HOLD(RH),
                   .TIMEOUT(TO), .RD_LAT(1), .CNT_W(CW1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .expect_neg(expect_neg),
    .dut_reset(dut_reset1), .dut_done(dut_done), .neg_cycle(neg_cycle),
    .om_addr(om_addr1), .om_data(om_data1), .gold_addr(gold_addr1), .gold_data(gold_data1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
    .mismatch_count(count1), .first_mismatch_addr(first1));

  assign om_data0   = om_mem[om_addr0[2:0]];
  assign gold_data0 = gold_mem[gold_addr0[2:0]];
  always @(posedge clock) begin
    om_data1   <= om_mem[om_addr1[2:0]];
    gold_data1 <= gold_mem[gold_addr1[2:0]];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input exp_t e, input int p, input int t,
                           input int c, input int f, input int ma, input int lat);
    chk({tag, " pass"}, p, e.pass);
    chk({tag, " timeout"}, t, e.tmo);
    chk({tag, " mismatch_count"}, c, e.cnt);
    chk({tag, " first_mismatch_addr"}, f, e.first);
    chk({tag, " max om_addr"}, ma, e.maxa);
    chk({tag, " latency"}, lat, e.lat);
  endtask

  // Reference: what the verdict should be given memory contents and DUT behaviour.
  function automatic exp_t model(input bit en, input bit neg, input int r,
                                 input int rdlat, input int maxc);
    exp_t e;
    int n;
    e = '{default: 0};
    if (r == 0) begin
      e.tmo = 1;
      e.lat = RH + TO + 1;
    end else if (en) begin
      e.pass = int'(neg);
      e.lat  = RH + r + 1 + 1;
    end else begin
      n = 0;
      for (int a = 0; a < NV; a++)
        if (om_mem[a] != gold_mem[a]) begin
          if (n == 0) e.first = a;
          n++;
        end
      e.cnt  = (n > maxc) ? maxc : n;
      e.pass = int'(n == 0 && !neg);
      e.maxa = NV - 1;
      e.lat  = RH + r + NV + rdlat + 1;
    end
    return e;
  endfunction

  // Monitor: pops an expectation on each rising done.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      max0 = 0; max1 = 0; done0_p = 0; done1_p = 0;
    end else begin
      if (busy0 && int'(om_addr0) > max0) max0 = int'(om_addr0);
      if (busy1 && int'(om_addr1) > max1) max1 = int'(om_addr1);
      if (done0 && !done0_p) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL dut0 unexpected done");
        end else begin
          e = q0.pop_front();
          check_res("dut0", e, int'(pass0), int'(timeout0), int'(count0), int'(first0),
                    max0, cyc - start_cyc + 1);
        end
        max0 = 0;
      end
      if (done1 && !done1_p) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL dut1 unexpected done");
        end else begin
          e = q1.pop_front();
          check_res("dut1", e, int'(pass1), int'(timeout1), int'(count1), int'(first1),
                    max1, cyc - start_cyc + 1);
        end
        max1 = 0;
      end
      done0_p = done0;
      done1_p = done1;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, " dut_reset0"}, int'(dut_reset0), 1);
    chk({tag, " dut_reset1"}, int'(dut_reset1), 1);
    chk({tag, " busy"}, int'({busy0, busy1}), 0);
    chk({tag, " done"}, int'({done0, done1}), 0);
    chk({tag, " pass"}, int'({pass0, pass1}), 0);
    chk({tag, " timeout"}, int'({timeout0, timeout1}), 0);
    chk({tag, " count0"}, int'(count0), 0);
    chk({tag, " count1"}, int'(count1), 0);
    chk({tag, " first0"}, int'(first0), 0);
    chk({tag, " first1"}, int'(first1), 0);
    chk({tag, " om_addr0"}, int'(om_addr0), 0);
    chk({tag, " om_addr1"}, int'(om_addr1), 0);
  endtask

  // pat: 0 equal, 1 differ at 3 and 6, 2 all differ, 3 random
  task automatic set_mem(input int pat);
    for (int a = 0; a < NV; a++) begin
      om_mem[a]   = DW'($urandom);
      gold_mem[a] = om_mem[a];
      if (pat == 2 || (pat == 1 && (a == 3 || a == 6)) ||
          (pat == 3 && $urandom_range(0, 3) == 0))
        gold_mem[a] = om_mem[a] ^ DW'($urandom_range(1, 65535));
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // r = RUN cycle in which dut_done is first seen; 0 = never
  task automatic run(input bit en, input bit neg, input int r, input bit extra, input bit drop);
    int edges;
    dut_done = 1'b0; neg_cycle = neg; expect_neg = en;
    q0.push_back(model(en, neg, r, 0, (1 << CW0) - 1));
    q1.push_back(model(en, neg, r, 1, (1 << CW1) - 1));
    pulse_start();
    start_cyc  = cyc;
    expect_neg = 1'($urandom);
    edges = RH + r - 1;
    if (extra) begin
      pulse_start();
      edges--;
    end
    if (r > 0) begin
      repeat (edges) @(posedge clock);
      #1 dut_done = 1'b1;
    end
    for (int k = 0; k < 400 && !(done0 && done1); k++) begin
      @(posedge clock);
      #1;
      if (drop && k == 2) dut_done = 1'b0;
    end
    if (!(done0 && done1)) begin
      n_cmp++; n_bad++;
      $display("FAIL run wait: done0=%0d done1=%0d required 1", done0, done1);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; expect_neg = 1'b0; dut_done = 1'b0; neg_cycle = 1'b0;
    set_mem(0);
    #3 chk_reset("reset");
    @(negedge clock);
    @(negedge clock) reset = 1'b0;

    set_mem(0); run(0, 0, 50, 0, 0);
    set_mem(1); run(0, 0, 20, 0, 0);
    set_mem(3); run(0, 0, 0, 0, 0);
    set_mem(3); run(1, 1, 15, 0, 0);
    set_mem(3); run(1, 0, 15, 1, 0);
    set_mem(0); run(0, 1, 10, 0, 1);
    set_mem(1); run(0, 0, TO, 0, 0);
    set_mem(2); run(0, 0, 5, 1, 1);

    // async reset in the middle of a scan, then a clean run
    set_mem(2);
    dut_done = 1'b0; neg_cycle = 1'b0; expect_neg = 1'b0;
    pulse_start();
    repeat (RH + 10 - 1) @(posedge clock);
    #1 dut_done = 1'b1;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1 chk_reset("midscan reset");
    #3 reset = 1'b0;
    q0.delete(); q1.delete();
    dut_done = 1'b0;
    set_mem(0); run(0, 0, 20, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int r;
      bit en, neg;
      en  = ($urandom_range(0, 3) == 0);
      neg = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       r = 0;
        1:       r = TO;
        default: r = $urandom_range(1, 60);
      endcase
      set_mem($urandom_range(0, 3));
      run(en, neg, r, 1'($urandom), 1'($urandom));
    end

    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover expectations: %0d/%0d required 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
